// File: rtl/physics_pkg.sv
// Shared types and constants for the player motion engine.
package physics_pkg;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } player_state_t;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the vsync-derived frame strobe into the Clk domain and turns each
// rising edge into a single-cycle tick. Flops reset high so a strobe that is
// already high when reset releases is not mistaken for a new frame.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  // two-flop synchronizer, edge-history flop, registered rising-edge pulse
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      sync_p2 <= 1'b1;
      tick    <= 1'b0;
    end else begin
      sync_p0 <= frame_clk;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      tick    <= sync_p1 & ~sync_p2;
    end
  end

endmodule

// File: rtl/player_physics.sv
// Per-frame player motion: horizontal walking with screen clamp, jump,
// gravity with terminal speed, and landing on the floor or one platform.
module player_physics #(
  parameter int X_START  = 320,
  parameter int Y_START  = 240,
  parameter int PLAYER_W = 8,
  parameter int PLAYER_H = 16,
  parameter int X_STEP   = 2,
  parameter int JUMP_VEL = 12,
  parameter int GRAVITY  = 1,
  parameter int VMAX     = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] PlatX,
  input  logic [9:0] PlatY,
  input  logic [9:0] PlatW,
  output logic [9:0] PlayerX,
  output logic [9:0] PlayerY,
  output logic [1:0] PlayerState
);

  import physics_pkg::*;

  localparam logic [9:0]        X_MAX   = 10'(SCREEN_W - PLAYER_W);
  localparam logic [9:0]        Y_FLOOR = 10'(SCREEN_H - PLAYER_H);
  localparam logic signed [10:0] FLOOR_S = 11'(SCREEN_H);
  localparam logic signed [10:0] H_S     = 11'(PLAYER_H);
  localparam logic signed [10:0] G_S     = 11'(GRAVITY);
  localparam logic signed [10:0] VMAX_S  = 11'(VMAX);
  localparam logic signed [10:0] VJUMP_S = 11'(-JUMP_VEL);

  function automatic logic [9:0] step_left(input logic [9:0] x);
    if (x < 10'(X_STEP)) return '0;
    return x - 10'(X_STEP);
  endfunction

  function automatic logic [9:0] step_right(input logic [9:0] x);
    logic [10:0] sum;
    sum = {1'b0, x} + 11'(X_STEP);
    if (sum > {1'b0, X_MAX}) return X_MAX;
    return sum[9:0];
  endfunction

  function automatic logic signed [10:0] sat_vy(input logic signed [10:0] v);
    if (v > VMAX_S) return VMAX_S;
    return v;
  endfunction

  logic tick;

  frame_tick_sync u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  logic [9:0]        pos_x, x_nxt;
  logic [9:0]        pos_y, y_nxt;
  logic signed [10:0] vel_y, vy_nxt;
  player_state_t     state, state_nxt;

  logic key_left, key_right, key_jump;
  assign key_left  = (keycode == KEY_A);
  assign key_right = (keycode == KEY_D);
  assign key_jump  = (keycode == KEY_W) || (keycode == KEY_SPACE);

  // Overlap uses 12 bits because PlatX+PlatW can exceed the 10-bit range.
  logic [11:0] x_ext, plat_l, plat_r;
  logic        overlap, supported;
  assign x_ext   = {2'b00, pos_x};
  assign plat_l  = {2'b00, PlatX};
  assign plat_r  = {2'b00, PlatX} + {2'b00, PlatW};
  assign overlap = ((x_ext + 12'(PLAYER_W)) > plat_l) && (x_ext < plat_r);

  logic signed [10:0] y_s, plat_y_s, y_bot, yn, yn_bot, vy_inc;
  assign y_s       = $signed({1'b0, pos_y});
  assign plat_y_s  = $signed({1'b0, PlatY});
  assign y_bot     = y_s + H_S;
  assign yn        = y_s + vel_y;
  assign yn_bot    = yn + H_S;
  assign vy_inc    = vel_y + G_S;
  assign supported = (y_bot == FLOOR_S) || ((y_bot == plat_y_s) && overlap);

  // next-state and datapath: everything holds except on a tick
  always_comb begin
    x_nxt     = pos_x;
    y_nxt     = pos_y;
    vy_nxt    = vel_y;
    state_nxt = state;
    if (tick) begin
      if (key_left)       x_nxt = step_left(pos_x);
      else if (key_right) x_nxt = step_right(pos_x);
      case (state)
        GROUNDED: begin
          if (key_jump) begin
            vy_nxt    = VJUMP_S;
            state_nxt = RISING;
          end else if (!supported) begin
            vy_nxt    = '0;
            state_nxt = FALLING;
          end
        end
        RISING: begin
          if (yn < 11'sd0) begin
            y_nxt     = '0;
            vy_nxt    = '0;
            state_nxt = FALLING;
          end else begin
            y_nxt  = yn[9:0];
            vy_nxt = vy_inc;
            if (vy_inc >= 11'sd0) state_nxt = FALLING;
          end
        end
        FALLING: begin
          if ((y_bot <= plat_y_s) && (yn_bot >= plat_y_s) && overlap) begin
            y_nxt     = PlatY - 10'(PLAYER_H);
            vy_nxt    = '0;
            state_nxt = GROUNDED;
          end else if (yn_bot >= FLOOR_S) begin
            y_nxt     = Y_FLOOR;
            vy_nxt    = '0;
            state_nxt = GROUNDED;
          end else begin
            y_nxt  = yn[9:0];
            vy_nxt = sat_vy(vy_inc);
          end
        end
        default: begin
          vy_nxt    = '0;
          state_nxt = FALLING;
        end
      endcase
    end
  end

  // state register; reset wins over a same-cycle tick
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pos_x <= 10'(X_START);
      pos_y <= 10'(Y_START);
      vel_y <= '0;
      state <= FALLING;
    end else begin
      pos_x <= x_nxt;
      pos_y <= y_nxt;
      vel_y <= vy_nxt;
      state <= state_nxt;
    end
  end

  assign PlayerX     = pos_x;
  assign PlayerY     = pos_y;
  assign PlayerState = state;

endmodule

// File: tb/tb_player_physics.sv
// Bench for player_physics: table-driven frame vectors with a reference
// model feeding a scoreboard queue, plus hand-built reset corner cases.
module tb_player_physics;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] PlatX, PlatY, PlatW;
  logic [9:0] PlayerX, PlayerY;
  logic [1:0] PlayerState;

  player_physics dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .PlatX       (PlatX),
    .PlatY       (PlatY),
    .PlatW       (PlatW),
    .PlayerX     (PlayerX),
    .PlayerY     (PlayerY),
    .PlayerState (PlayerState)
  );

  always #5 Clk = ~Clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, summary not yet printed");
    $fatal(1, "watchdog");
  end

  typedef struct { int x; int y; int st; } exp_t;
  typedef struct { logic [7:0] key; int x; int y; int st; } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_x, m_y, m_vy, m_st;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 320; m_y = 240; m_vy = 0; m_st = 2;
  endtask

  task automatic model_step(input logic [7:0] k);
    int px, py, pw, nx, ny, nv, st, yn;
    bit ov, sup, jump;
    px = int'(PlatX); py = int'(PlatY); pw = int'(PlatW);
    ov   = (m_x + 8 > px) && (m_x < px + pw);
    sup  = (m_y + 16 == 480) || ((m_y + 16 == py) && ov);
    jump = (k == 8'h1A) || (k == 8'h2C);
    nx = m_x;
    if (k == 8'h04)      nx = (m_x - 2 < 0) ? 0 : m_x - 2;
    else if (k == 8'h07) nx = (m_x + 2 > 632) ? 632 : m_x + 2;
    ny = m_y; nv = m_vy; st = m_st; yn = m_y + m_vy;
    case (m_st)
      0: begin
        if (jump)      begin nv = -12; st = 1; end
        else if (!sup) begin nv = 0;   st = 2; end
      end
      1: begin
        if (yn < 0) begin ny = 0; nv = 0; st = 2; end
        else begin
          ny = yn; nv = m_vy + 1;
          if (nv >= 0) st = 2;
        end
      end
      default: begin
        if ((m_y + 16 <= py) && (yn + 16 >= py) && ov) begin
          ny = py - 16; nv = 0; st = 0;
        end else if (yn + 16 >= 480) begin
          ny = 464; nv = 0; st = 0;
        end else begin
          ny = yn; nv = (m_vy + 1 > 8) ? 8 : m_vy + 1;
        end
      end
    endcase
    m_x = nx; m_y = ny; m_vy = nv; m_st = st;
  endtask

  // One frame strobe, high for 'hold' cycles; called at posedge+1.
  task automatic run_frame(input logic [7:0] key, input int hold, input string tag);
    exp_t e, pre;
    pre.x = m_x; pre.y = m_y; pre.st = m_st;
    model_step(key);
    e.x = m_x; e.y = m_y; e.st = m_st;
    sb.push_back(e);
    keycode   = key;
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check({tag, " early_x"},  int'(PlayerX),     pre.x);
    check({tag, " early_y"},  int'(PlayerY),     pre.y);
    check({tag, " early_st"}, int'(PlayerState), pre.st);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check({tag, " x"},  int'(PlayerX),     e.x);
    check({tag, " y"},  int'(PlayerY),     e.y);
    check({tag, " st"}, int'(PlayerState), e.st);
    if (hold > 4) begin
      repeat (hold - 4) @(posedge Clk);
      #1;
    end
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    check({tag, " hold_x"}, int'(PlayerX), e.x);
    check({tag, " hold_y"}, int'(PlayerY), e.y);
  endtask

  task automatic add_vec(input logic [7:0] k, input int x, input int y, input int st);
    vec_t v;
    v.key = k; v.x = x; v.y = y; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic apply_tbl(input string tag);
    foreach (tbl[i]) begin
      run_frame(tbl[i].key, (i == 0) ? 12 : 4, $sformatf("%s[%0d]", tag, i));
      check($sformatf("%s[%0d] tbl_x", tag, i),  int'(PlayerX),     tbl[i].x);
      check($sformatf("%s[%0d] tbl_y", tag, i),  int'(PlayerY),     tbl[i].y);
      check($sformatf("%s[%0d] tbl_st", tag, i), int'(PlayerState), tbl[i].st);
    end
    tbl.delete();
  endtask

  int ff_y[10] = '{240, 241, 243, 246, 250, 255, 261, 268, 276, 284};
  int jp_y[12] = '{272, 261, 251, 242, 234, 227, 221, 216, 212, 209, 207, 206};

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00;
    PlatX = 10'd316; PlatY = 10'd300; PlatW = 10'd16;
    repeat (50) @(posedge Clk);
    #1;
    check("reset x",  int'(PlayerX),     320);
    check("reset y",  int'(PlayerY),     240);
    check("reset st", int'(PlayerState), 2);

    // strobe already high with a walk key when reset releases: no tick
    frame_clk = 1'b1; keycode = 8'h07;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    check("release_high x",  int'(PlayerX),     320);
    check("release_high st", int'(PlayerState), 2);
    frame_clk = 1'b0; keycode = 8'h00;
    repeat (30) @(posedge Clk);
    #1;
    check("idle x", int'(PlayerX), 320);
    check("idle y", int'(PlayerY), 240);
    model_reset();

    // free fall onto the platform
    for (int i = 0; i < 10; i++) add_vec(8'h00, 320, ff_y[i], (i == 9) ? 0 : 2);
    apply_tbl("fall");

    // jump from the platform, then fall back
    add_vec(8'h2C, 320, 284, 1);
    for (int i = 0; i < 12; i++) add_vec(8'h00, 320, jp_y[i], (i == 11) ? 2 : 1);
    apply_tbl("jump");
    for (int i = 0; i < 40 && m_st != 0; i++) run_frame(8'h00, 4, "fallback");
    check("jump_land y",  int'(PlayerY),     284);
    check("jump_land st", int'(PlayerState), 0);

    // walk right off the platform edge; first frame held high for 12 cycles
    for (int i = 0; i < 6; i++) add_vec(8'h07, 322 + 2 * i, 284, 0);
    add_vec(8'h07, 334, 284, 2);
    apply_tbl("walk");
    for (int i = 0; i < 40 && m_st != 0; i++) run_frame(8'h07, 4, "walkfall");
    check("floor y",  int'(PlayerY),     464);
    check("floor st", int'(PlayerState), 0);

    // right clamp
    for (int i = 0; i < 400 && m_x < 630; i++) run_frame(8'h07, 4, "to_right");
    check("at630 x", int'(PlayerX), 630);
    run_frame(8'h07, 4, "clamp_r1");
    check("clamp_r1 x", int'(PlayerX), 632);
    run_frame(8'h07, 4, "clamp_r2");
    check("clamp_r2 x", int'(PlayerX), 632);

    // left clamp
    for (int i = 0; i < 400 && m_x > 2; i++) run_frame(8'h04, 4, "to_left");
    check("at2 x", int'(PlayerX), 2);
    run_frame(8'h04, 4, "clamp_l1");
    check("clamp_l1 x", int'(PlayerX), 0);
    run_frame(8'h04, 4, "clamp_l2");
    check("clamp_l2 x", int'(PlayerX), 0);

    // reset landing on the same edge as a tick, mid-jump
    run_frame(8'h1A, 4, "jump2");
    run_frame(8'h00, 4, "jump2b");
    check("mid_jump st", int'(PlayerState), 1);
    keycode = 8'h04; frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("rst_tick x",  int'(PlayerX),     320);
    check("rst_tick y",  int'(PlayerY),     240);
    check("rst_tick st", int'(PlayerState), 2);
    Reset = 1'b0; frame_clk = 1'b0; keycode = 8'h00;
    repeat (4) @(posedge Clk);
    #1;
    model_reset();
    run_frame(8'h00, 4, "post_rst1");
    check("post_rst1 y", int'(PlayerY), 240);
    run_frame(8'h00, 4, "post_rst2");
    check("post_rst2 y", int'(PlayerY), 241);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
